clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Time-setting sequencer for the BCD clock counter.
- Takes debounced single-cycle button pulses and walks an FSM through hour, minute and second edit states. Edits happen in shadow registers, not in the live time.
- Drives the counter's set_en / set_load / set_hh / set_mm / set_ss inputs.
- Provides the display mux and blink mask for the 7-segment driver.

Parameters:
- TIMEOUT_S, 10, number of 1 Hz ticks with no button activity before edit mode aborts without loading (range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_1hz_tick  in  1  one-cycle 1 Hz pulse; drives the timeout
- blink_tick  in  1  one-cycle pulse; toggles the blink phase
- btn_mode  in  1  debounced one-cycle pulse; advances the edit field
- btn_inc  in  1  debounced one-cycle pulse; increments the selected field
- cur_hh  in  8  live BCD hours from the counter
- cur_mm  in  8  live BCD minutes from the counter
- cur_ss  in  8  live BCD seconds from the counter
- set_en  out  1  high in every non-RUN state; stalls the counter
- set_load  out  1  one-cycle load strobe
- set_hh  out  8  shadow BCD hours
- set_mm  out  8  shadow BCD minutes
- set_ss  out  8  shadow BCD seconds
- disp_hh  out  8  cur_hh in RUN, else set_hh (combinational mux)
- disp_mm  out  8  cur_mm in RUN, else set_mm (combinational mux)
- disp_ss  out  8  cur_ss in RUN, else set_ss (combinational mux)
- blink_mask  out  3  [2]=hh, [1]=mm, [0]=ss; bit of the edited field is set while blink phase is 1
- editing  out  1  high in SET_HH, SET_MM, SET_SS

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - state=RUN
  - set_en=0, set_load=0
  - set_hh/mm/ss=8'h00
  - blink phase=0, blink_mask=0
  - timeout counter=0
- Reset mid-edit discards the shadow and issues no load.
- FSM states: RUN, SET_HH, SET_MM, SET_SS, LOAD. All outputs are registered except the disp_* mux.
- RUN -> SET_HH on btn_mode:
  - same edge: capture cur_hh/mm/ss into set_hh/mm/ss
  - clear timeout counter
  - set blink phase=1
- SET_HH -> SET_MM -> SET_SS on btn_mode.
- SET_SS -> LOAD on btn_mode.
- LOAD:
  - lasts exactly one cycle with set_load=1 and set_en=1
  - unconditionally -> RUN next cycle
  - set_en falls in the same cycle set_load falls
- btn_inc in a SET_* state increments the selected shadow field in BCD:
  - low nibble 9 -> 0 and carry to the high nibble
  - hh wraps 8'h23 -> 8'h00; mm and ss wrap 8'h59 -> 8'h00
  - no carry into adjacent fields
- btn_inc in RUN or LOAD is ignored.
- btn_mode and btn_inc in the same cycle: mode wins, inc is dropped.
- Timeout:
  - in SET_* states, each clk_1hz_tick increments the counter
  - any btn_mode or btn_inc clears it (button has priority over a coincident tick)
  - reaching TIMEOUT_S -> RUN without set_load; shadow is retained but unused
- Blink: blink phase toggles on blink_tick in SET_* states and is forced to 0 in RUN and LOAD.
- Input sanitising: cur_* values are captured as-is. An out-of-range captured field (e.g. hh=8'h25) is corrected by the first increment, which returns 8'h00.

Optional Feature:
- SET_DEC_EN defined:
  - adds input port btn_dec (1 bit, one-cycle pulse)
  - btn_dec in a SET_* state decrements the selected field in BCD: low nibble 0 -> 9 with borrow
  - wrap: hh 8'h00 -> 8'h23; mm and ss 8'h00 -> 8'h59
  - btn_dec clears the timeout counter
  - priority: mode > inc > dec
- SET_DEC_EN undefined: no btn_dec port; increment only.

Test Plan:
- rst=1 for 2 cycles then 0 -> state RUN; set_en=0, set_load=0, set_*=00, blink_mask=0; disp_* equals cur_*.
- cur=13:45:27, btn_mode -> next cycle editing=1, set_en=1, set=13:45:27. Then 11 btn_inc -> set_hh=8'h00 (13+11 wraps via 23 -> 00).
- In SET_MM with set_mm=8'h59, btn_inc -> set_mm=8'h00 and set_hh unchanged. In SET_SS with set_ss=8'h09, btn_inc -> set_ss=8'h10.
- Full sequence mode, mode, mode, mode -> set_load high for exactly one cycle after the 4th mode, with set=captured/edited value. set_en drops the same cycle set_load drops.
- TIMEOUT_S=3, enter SET_HH, send 3 clk_1hz_tick with no buttons -> return to RUN with no set_load pulse. Repeat with btn_inc coincident with the 3rd tick -> stays in SET_HH.
- btn_mode and btn_inc in the same cycle in SET_HH -> state SET_MM, set_hh unchanged. With SET_DEC_EN: set_hh=8'h00 plus btn_dec -> 8'h23; set_ss=8'h10 plus btn_dec -> 8'h09.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: edits hh/mm/ss in shadow registers and strobes them into the BCD counter.
// Optional macro SET_DEC_EN adds the btn_dec port and BCD decrement of the selected field.
module clock_set_ctrl #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz_tick,
    input  logic       blink_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
`ifdef SET_DEC_EN
    input  logic       btn_dec,
`endif
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    output logic       set_en,
    output logic       set_load,
    output logic [7:0] set_hh,
    output logic [7:0] set_mm,
    output logic [7:0] set_ss,
    output logic [7:0] disp_hh,
    output logic [7:0] disp_mm,
    output logic [7:0] disp_ss,
    output logic [2:0] blink_mask,
    output logic       editing
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HH,
        ST_SET_MM,
        ST_SET_SS,
        ST_LOAD
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_S - 1);

    // Out-of-range or malformed fields snap to 00 on increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        if (v[3:0] > 4'd9 || v >= vmax) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
        return v + 8'd1;
    endfunction

`ifdef SET_DEC_EN
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        if (v[3:0] > 4'd9 || v > vmax || v == 8'h00) return vmax;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'h9};
        return v - 8'd1;
    endfunction
`endif

    state_t     state_q, state_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       blink_q, blink_d;
    logic [2:0] mask_q, mask_d;
    logic       set_en_q, set_load_q, editing_q;
    logic       in_edit, btn_any, do_capture, do_inc;
    logic [1:0] sel_field;
    logic [23:0] cur_bus, shadow;

    assign cur_bus = {cur_hh, cur_mm, cur_ss};
    assign in_edit = (state_q == ST_SET_HH) || (state_q == ST_SET_MM) || (state_q == ST_SET_SS);

`ifdef SET_DEC_EN
    logic do_dec;
    assign btn_any = btn_mode | btn_inc | btn_dec;
    assign do_dec  = in_edit && !btn_mode && !btn_inc && btn_dec;
`else
    assign btn_any = btn_mode | btn_inc;
`endif

    assign do_capture = (state_q == ST_RUN) && btn_mode;
    assign do_inc     = in_edit && !btn_mode && btn_inc;

    always_comb begin
        case (state_q)
            ST_SET_HH: sel_field = 2'd2;
            ST_SET_MM: sel_field = 2'd1;
            default:   sel_field = 2'd0;
        endcase
    end

    // Shadow field gi: 0 = ss, 1 = mm, 2 = hh (same order as blink_mask bits).
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field
            localparam logic [7:0] FMAX = (gi == 2) ? 8'h23 : 8'h59;
            logic [7:0] field_q, field_d;
            logic       sel_here;

            assign sel_here = (sel_field == 2'(gi));

            always_comb begin
                field_d = field_q;
                if (do_capture) begin
                    field_d = cur_bus[gi*8 +: 8];
                end else if (do_inc && sel_here) begin
                    field_d = bcd_inc(field_q, FMAX);
`ifdef SET_DEC_EN
                end else if (do_dec && sel_here) begin
                    field_d = bcd_dec(field_q, FMAX);
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (rst) field_q <= 8'h00;
                else     field_q <= field_d;
            end

            assign shadow[gi*8 +: 8] = field_q;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        blink_d = blink_q;
        case (state_q)
            ST_RUN: begin
                tcnt_d = 8'd0;
                if (btn_mode) begin
                    state_d = ST_SET_HH;
                    blink_d = 1'b1;
                end
            end
            ST_SET_HH, ST_SET_MM, ST_SET_SS: begin
                if (btn_mode) begin
                    case (state_q)
                        ST_SET_HH: state_d = ST_SET_MM;
                        ST_SET_MM: state_d = ST_SET_SS;
                        default:   state_d = ST_LOAD;
                    endcase
                end
                // A button press outranks a coincident 1 Hz tick.
                if (btn_any) begin
                    tcnt_d = 8'd0;
                end else if (clk_1hz_tick) begin
                    if (tcnt_q == TO_LAST) begin
                        state_d = ST_RUN;
                        tcnt_d  = 8'd0;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
                if (blink_tick) blink_d = !blink_q;
            end
            default: begin
                state_d = ST_RUN;
                tcnt_d  = 8'd0;
            end
        endcase
        if (state_d == ST_RUN || state_d == ST_LOAD) blink_d = 1'b0;
    end

    always_comb begin
        mask_d = 3'b000;
        if (blink_d) begin
            case (state_d)
                ST_SET_HH: mask_d = 3'b100;
                ST_SET_MM: mask_d = 3'b010;
                ST_SET_SS: mask_d = 3'b001;
                default:   mask_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            tcnt_q     <= 8'd0;
            blink_q    <= 1'b0;
            mask_q     <= 3'b000;
            set_en_q   <= 1'b0;
            set_load_q <= 1'b0;
            editing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            blink_q    <= blink_d;
            mask_q     <= mask_d;
            set_en_q   <= (state_d != ST_RUN);
            set_load_q <= (state_d == ST_LOAD);
            editing_q  <= (state_d == ST_SET_HH) || (state_d == ST_SET_MM) || (state_d == ST_SET_SS);
        end
    end

    assign set_en     = set_en_q;
    assign set_load   = set_load_q;
    assign editing    = editing_q;
    assign blink_mask = mask_q;
    assign set_hh     = shadow[23:16];
    assign set_mm     = shadow[15:8];
    assign set_ss     = shadow[7:0];

    assign disp_hh = (state_q == ST_RUN) ? cur_hh : set_hh;
    assign disp_mm = (state_q == ST_RUN) ? cur_mm : set_mm;
    assign disp_ss = (state_q == ST_RUN) ? cur_ss : set_ss;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized traffic
// checked against a decimal-arithmetic reference model of the edit sequencer.
module tb_clock_set_ctrl;

    localparam int T = 3;

    logic       clk = 1'b0;
    logic       rst, tick, bt, mode, inc, dec;
    logic [7:0] cur_hh, cur_mm, cur_ss;
    logic       set_en, set_load, editing;
    logic [7:0] set_hh, set_mm, set_ss, disp_hh, disp_mm, disp_ss;
    logic [2:0] blink_mask;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_st 0=RUN, 1=SET_HH, 2=SET_MM, 3=SET_SS, 4=LOAD; m_f[0]=ss,[1]=mm,[2]=hh as decimal.
    int m_st, m_tcnt, m_blink;
    int m_f[3];

    clock_set_ctrl #(.TIMEOUT_S(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_1hz_tick (tick),
        .blink_tick   (bt),
        .btn_mode     (mode),
        .btn_inc      (inc),
`ifdef SET_DEC_EN
        .btn_dec      (dec),
`endif
        .cur_hh       (cur_hh),
        .cur_mm       (cur_mm),
        .cur_ss       (cur_ss),
        .set_en       (set_en),
        .set_load     (set_load),
        .set_hh       (set_hh),
        .set_mm       (set_mm),
        .set_ss       (set_ss),
        .disp_hh      (disp_hh),
        .disp_mm      (disp_mm),
        .disp_ss      (disp_ss),
        .blink_mask   (blink_mask),
        .editing      (editing)
    );

    always #5 clk = ~clk;

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int fmax(input int fi);
        return (fi == 2) ? 23 : 59;
    endfunction

    task automatic model_update(input logic r, input logic m, input logic i, input logic d,
                                input logic t, input logic b);
        int fi;
        if (r) begin
            m_st = 0; m_tcnt = 0; m_blink = 0;
            for (int k = 0; k < 3; k++) m_f[k] = 0;
            return;
        end
        if (m_st == 0) begin
            if (m) begin
                m_f[2] = bcd2i(cur_hh); m_f[1] = bcd2i(cur_mm); m_f[0] = bcd2i(cur_ss);
                m_st = 1; m_tcnt = 0; m_blink = 1;
            end
        end else if (m_st == 4) begin
            m_st = 0; m_blink = 0;
        end else begin
            fi = 3 - m_st;
            if (m) begin
                m_st = m_st + 1; m_tcnt = 0;
            end else if (i) begin
                m_f[fi] = (m_f[fi] >= fmax(fi)) ? 0 : m_f[fi] + 1;
                m_tcnt = 0;
`ifdef SET_DEC_EN
            end else if (d) begin
                m_f[fi] = (m_f[fi] == 0 || m_f[fi] > fmax(fi)) ? fmax(fi) : m_f[fi] - 1;
                m_tcnt = 0;
`endif
            end else if (t) begin
                m_tcnt++;
                if (m_tcnt == T) begin m_st = 0; m_tcnt = 0; end
            end
            if (m_st == 0 || m_st == 4) m_blink = 0;
            else if (b) m_blink = !m_blink;
        end
        if (d && 0) m_tcnt = m_tcnt;
    endtask

    // One clock: drive pulses, take the edge, advance the model, release pulses 1 ns later.
    task automatic cycle(input logic r, input logic m, input logic i, input logic d,
                         input logic t, input logic b);
        rst = r; mode = m; inc = i; dec = d; tick = t; bt = b;
        @(posedge clk);
        model_update(r, m, i, d, t, b);
        #1;
        rst = 0; mode = 0; inc = 0; dec = 0; tick = 0; bt = 0;
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        cur_hh = h; cur_mm = mi; cur_ss = s;
    endtask

    task automatic test_reset;
        set_cur(8'h13, 8'h45, 8'h27);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({set_en, set_load, editing, blink_mask} !== 6'b000000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 000000", {set_en, set_load, editing, blink_mask});
        end
        n_cmp++;
        if ({set_hh, set_mm, set_ss} !== 24'h000000) begin
            n_bad++; $display("FAIL reset_shadow: got %h expected 000000", {set_hh, set_mm, set_ss});
        end
        n_cmp++;
        if ({disp_hh, disp_mm, disp_ss} !== 24'h134527) begin
            n_bad++; $display("FAIL reset_disp: got %h expected 134527", {disp_hh, disp_mm, disp_ss});
        end
        $display("reset done");
    endtask

    task automatic test_capture_inc;
        cycle(0, 1, 0, 0, 0, 0);
        set_cur(8'h01, 8'h02, 8'h03);
        n_cmp++;
        if ({editing, set_en, set_load, blink_mask} !== 6'b110100) begin
            n_bad++; $display("FAIL capture_ctrl: got %b expected 110100", {editing, set_en, set_load, blink_mask});
        end
        n_cmp++;
        if ({set_hh, set_mm, set_ss} !== 24'h134527) begin
            n_bad++; $display("FAIL capture_val: got %h expected 134527", {set_hh, set_mm, set_ss});
        end
        n_cmp++;
        if ({disp_hh, disp_mm, disp_ss} !== 24'h134527) begin
            n_bad++; $display("FAIL capture_disp: got %h expected 134527", {disp_hh, disp_mm, disp_ss});
        end
        for (int k = 0; k < 10; k++) cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (set_hh !== 8'h23) begin
            n_bad++; $display("FAIL inc_hh_23: got %h expected 23", set_hh);
        end
        cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (set_hh !== 8'h00) begin
            n_bad++; $display("FAIL inc_hh_wrap: got %h expected 00", set_hh);
        end
        $display("capture+11 inc: hh=%h", set_hh);
    endtask

    task automatic test_wrap;
        cycle(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (set_mm !== 8'h59) begin
            n_bad++; $display("FAIL inc_mm_59: got %h expected 59", set_mm);
        end
        cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({set_hh, set_mm, blink_mask} !== {8'h00, 8'h00, 3'b010}) begin
            n_bad++; $display("FAIL mm_wrap: got %h %h %b expected 00 00 010", set_hh, set_mm, blink_mask);
        end
        cycle(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 42; k++) cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (set_ss !== 8'h09) begin
            n_bad++; $display("FAIL ss_09: got %h expected 09", set_ss);
        end
        cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (set_ss !== 8'h10) begin
            n_bad++; $display("FAIL ss_carry: got %h expected 10", set_ss);
        end
        $display("field wrap: %h:%h:%h", set_hh, set_mm, set_ss);
    endtask

    task automatic test_load;
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++;
        if ({set_load, set_en, editing, blink_mask} !== 6'b110000) begin
            n_bad++; $display("FAIL load_strobe: got %b expected 110000", {set_load, set_en, editing, blink_mask});
        end
        n_cmp++;
        if ({set_hh, set_mm, set_ss} !== 24'h000010) begin
            n_bad++; $display("FAIL load_val: got %h expected 000010", {set_hh, set_mm, set_ss});
        end
        cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({set_load, set_en, editing, set_ss} !== {3'b000, 8'h10}) begin
            n_bad++; $display("FAIL load_end: got %b %h expected 000 10", {set_load, set_en, editing}, set_ss);
        end
        cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({set_load, set_en, set_ss} !== {2'b00, 8'h10}) begin
            n_bad++; $display("FAIL run_inc_ignored: got %b %h expected 00 10", {set_load, set_en}, set_ss);
        end
        $display("load strobe one cycle");
    endtask

    task automatic test_timeout;
        int loads;
        loads = 0;
        set_cur(8'h08, 8'h30, 8'h00);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0); loads += int'(set_load);
        cycle(0, 0, 0, 0, 1, 0); loads += int'(set_load);
        n_cmp++;
        if (editing !== 1'b1) begin
            n_bad++; $display("FAIL timeout_early: got editing=%b expected 1", editing);
        end
        cycle(0, 0, 0, 0, 1, 0); loads += int'(set_load);
        n_cmp++;
        if ({editing, set_en, set_load} !== 3'b000 || loads != 0) begin
            n_bad++; $display("FAIL timeout_abort: got %b loads=%0d expected 000 loads=0", {editing, set_en, set_load}, loads);
        end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 1, 0);
        n_cmp++;
        if ({editing, set_hh} !== {1'b1, 8'h09}) begin
            n_bad++; $display("FAIL timeout_btn_prio: got %b %h expected 1 09", editing, set_hh);
        end
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (editing !== 1'b1) begin
            n_bad++; $display("FAIL timeout_restart: got editing=%b expected 1", editing);
        end
        cycle(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if ({editing, set_load} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_abort2: got %b expected 00", {editing, set_load});
        end
        $display("timeout abort x2");
    endtask

    task automatic test_priority;
        set_cur(8'h11, 8'h22, 8'h33);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        n_cmp++;
        if ({set_hh, set_mm, blink_mask, editing} !== {8'h11, 8'h22, 3'b010, 1'b1}) begin
            n_bad++; $display("FAIL mode_over_inc: got %h %h %b %b expected 11 22 010 1", set_hh, set_mm, blink_mask, editing);
        end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        $display("mode beats inc");
    endtask

    task automatic test_blink;
        set_cur(8'h12, 8'h00, 8'h00);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (blink_mask !== 3'b000) begin
            n_bad++; $display("FAIL blink_off: got %b expected 000", blink_mask);
        end
        cycle(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (blink_mask !== 3'b100) begin
            n_bad++; $display("FAIL blink_on: got %b expected 100", blink_mask);
        end
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (blink_mask !== 3'b010) begin
            n_bad++; $display("FAIL blink_mm: got %b expected 010", blink_mask);
        end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1);
        n_cmp++;
        if ({set_load, blink_mask} !== 4'b1000) begin
            n_bad++; $display("FAIL blink_load: got %b expected 1000", {set_load, blink_mask});
        end
        cycle(0, 0, 0, 0, 0, 0);
        $display("blink phase");
    endtask

    task automatic test_out_of_range;
        set_cur(8'h25, 8'h10, 8'h10);
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (set_hh !== 8'h25) begin
            n_bad++; $display("FAIL oor_capture: got %h expected 25", set_hh);
        end
        cycle(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (set_hh !== 8'h00) begin
            n_bad++; $display("FAIL oor_fix: got %h expected 00", set_hh);
        end
        // Reset mid-edit: shadow cleared, no load.
        cycle(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({set_load, set_en, editing, set_mm} !== {3'b000, 8'h00}) begin
            n_bad++; $display("FAIL reset_mid_edit: got %b %h expected 000 00", {set_load, set_en, editing}, set_mm);
        end
        $display("out-of-range capture fixed");
    endtask

`ifdef SET_DEC_EN
    task automatic test_dec;
        set_cur(8'h00, 8'h00, 8'h10);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (set_hh !== 8'h23) begin
            n_bad++; $display("FAIL dec_hh_wrap: got %h expected 23", set_hh);
        end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (set_ss !== 8'h09) begin
            n_bad++; $display("FAIL dec_ss_borrow: got %h expected 09", set_ss);
        end
        cycle(0, 0, 1, 1, 0, 0);
        n_cmp++;
        if (set_ss !== 8'h10) begin
            n_bad++; $display("FAIL inc_over_dec: got %h expected 10", set_ss);
        end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        $display("decrement");
    endtask
`endif

    task automatic test_random;
        logic [54:0] got, want;
        logic [7:0]  eh, em, es;
        logic [2:0]  emask;
        logic        r, m, i, d, t, b;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0)
                set_cur(i2bcd(int'($urandom_range(0, 23))), i2bcd(int'($urandom_range(0, 59))),
                        i2bcd(int'($urandom_range(0, 59))));
            r = ($urandom_range(0, 199) == 0);
            m = ($urandom_range(0, 5) == 0);
            i = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 3) == 0);
            cycle(r, m, i, d, t, b);
            eh = i2bcd(m_f[2]); em = i2bcd(m_f[1]); es = i2bcd(m_f[0]);
            emask = (m_blink != 0 && m_st >= 1 && m_st <= 3) ? 3'(1 << (3 - m_st)) : 3'b000;
            want = {m_st != 0, m_st == 4, m_st >= 1 && m_st <= 3, emask, eh, em, es,
                    (m_st == 0) ? {cur_hh, cur_mm, cur_ss} : {eh, em, es}};
            got = {set_en, set_load, editing, blink_mask, set_hh, set_mm, set_ss,
                   disp_hh, disp_mm, disp_ss};
            n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL random[%0d]: got %h expected %h", n, got, want);
            end
            if (set_load === 1'b1) $display("random load %h:%h:%h", set_hh, set_mm, set_ss);
        end
    endtask

    initial begin
        rst = 1; mode = 0; inc = 0; dec = 0; tick = 0; bt = 0;
        set_cur(8'h00, 8'h00, 8'h00);
        m_st = 0; m_tcnt = 0; m_blink = 0;
        for (int k = 0; k < 3; k++) m_f[k] = 0;
        test_reset;
        test_capture_inc;
        test_wrap;
        test_load;
        test_timeout;
        test_priority;
        test_blink;
        test_out_of_range;
`ifdef SET_DEC_EN
        test_dec;
`endif
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
